// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct/REGIMM-rt encodings,
// instruction field positions, the link register number and the
// branch-condition selector used by branch_cmp.
package mips_pkg;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IDX_HI   = 25;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    CMP_EQ,
    CMP_NE,
    CMP_LEZ,
    CMP_GTZ,
    CMP_LTZ,
    CMP_GEZ,
    CMP_ALWAYS
  } cmp_sel_e;

  // Branch displacement: sign-extended word offset converted to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator (combinational).
//   i_sel   : condition select
//   i_rs    : rs operand (signed)
//   i_rt    : rt operand (signed)
//   o_taken : condition holds
module branch_cmp
  import mips_pkg::*;
(
  input  cmp_sel_e    i_sel,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = i_rs[31];
  assign w_rs_zero = (i_rs == '0);

  always_comb begin
    o_taken = 1'b0;
    case (i_sel)
      CMP_EQ:     o_taken = (i_rs == i_rt);
      CMP_NE:     o_taken = (i_rs != i_rt);
      CMP_LEZ:    o_taken = w_rs_neg | w_rs_zero;
      CMP_GTZ:    o_taken = ~w_rs_neg & ~w_rs_zero;
      CMP_LTZ:    o_taken = w_rs_neg;
      CMP_GEZ:    o_taken = ~w_rs_neg;
      CMP_ALWAYS: o_taken = 1'b1;
      default:    o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Control-transfer resolver: decodes the instruction at pc, evaluates the
// branch condition, registers the taken target so the PC jumps after the
// delay slot, and supplies link-register write data.
//   clk, rst          : clock, synchronous active-high reset
//   pc, instr         : executing instruction and its address
//   instr_valid       : instr is architecturally executing
//   rs_val, rt_val    : register operands
//   jmp, jmp_adr      : registered jump request and target
//   link_we/reg/val   : combinational link write (val = pc + 8)
//   dslot_err         : one-cycle pulse, transfer found in a delay slot
module branch_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        jmp,
  output logic [31:0] jmp_adr,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_val,
  output logic        dslot_err
);

  typedef enum logic {ST_IDLE, ST_SLOT} state_e;

  state_e      r_state;
  state_e      w_next;

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [5:0]  w_funct;
  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;

  logic        w_xfer;
  logic        w_link;
  logic [31:0] w_tgt;
  cmp_sel_e    w_sel;
  logic        w_taken;
  logic        w_capture;
  logic        w_dslot_set;

  assign w_op     = instr[OP_HI:OP_LO];
  assign w_rt     = instr[RT_HI:RT_LO];
  assign w_funct  = instr[FUNCT_HI:FUNCT_LO];
  assign w_pc4    = pc + 32'd4;
  assign w_br_tgt = w_pc4 + br_offset(instr[IMM_HI:0]);
  assign w_j_tgt  = {w_pc4[31:28], instr[IDX_HI:0], 2'b00};
  assign link_val = pc + 32'd8;

  always_comb begin
    w_xfer   = 1'b0;
    w_link   = 1'b0;
    w_sel    = CMP_ALWAYS;
    w_tgt    = w_br_tgt;
    link_reg = REG_RA;
    case (w_op)
      OP_SPECIAL: begin
        if (w_funct == FN_JR || w_funct == FN_JALR) begin
          w_xfer = 1'b1;
          w_tgt  = rs_val;
          if (w_funct == FN_JALR) begin
            w_link   = 1'b1;
            link_reg = instr[RD_HI:RD_LO];
          end
        end
      end
      OP_REGIMM: begin
        case (w_rt)
          RT_BLTZ:   begin w_xfer = 1'b1; w_sel = CMP_LTZ; end
          RT_BGEZ:   begin w_xfer = 1'b1; w_sel = CMP_GEZ; end
          RT_BLTZAL: begin w_xfer = 1'b1; w_sel = CMP_LTZ; w_link = 1'b1; end
          RT_BGEZAL: begin w_xfer = 1'b1; w_sel = CMP_GEZ; w_link = 1'b1; end
          default:   ;
        endcase
      end
      OP_J:    begin w_xfer = 1'b1; w_tgt = w_j_tgt; end
      OP_JAL:  begin w_xfer = 1'b1; w_tgt = w_j_tgt; w_link = 1'b1; end
      OP_BEQ:  begin w_xfer = 1'b1; w_sel = CMP_EQ;  end
      OP_BNE:  begin w_xfer = 1'b1; w_sel = CMP_NE;  end
      OP_BLEZ: begin w_xfer = 1'b1; w_sel = CMP_LEZ; end
      OP_BGTZ: begin w_xfer = 1'b1; w_sel = CMP_GTZ; end
      default: ;
    endcase
  end

  branch_cmp u_cmp (
    .i_sel   (w_sel),
    .i_rs    (rs_val),
    .i_rt    (rt_val),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Link writes happen regardless of branch outcome but never from a
  // delay-slot instruction; writes to r0 are dropped.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_dslot_set = 1'b0;
    link_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid && w_xfer && w_taken) begin
          w_capture = 1'b1;
          w_next    = ST_SLOT;
        end
        link_we = instr_valid && w_link && (link_reg != '0);
      end
      ST_SLOT: begin
        w_next      = ST_IDLE;
        w_dslot_set = instr_valid && w_xfer;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jmp_adr   <= '0;
      dslot_err <= 1'b0;
    end else begin
      if (w_capture) jmp_adr <= w_tgt;
      dslot_err <= w_dslot_set;
    end
  end

  assign jmp = (r_state == ST_SLOT);

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        jmp;
  logic [31:0] jmp_adr;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_val;
  logic        dslot_err;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  branch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .jmp         (jmp),
    .jmp_adr     (jmp_adr),
    .link_we     (link_we),
    .link_reg    (link_reg),
    .link_val    (link_val),
    .dslot_err   (dslot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  // Architectural meaning of one instruction.
  typedef struct packed {
    logic        xfer;
    logic        taken;
    logic        link;
    logic [4:0]  lreg;
    logic [31:0] tgt;
  } dec_t;

  function automatic dec_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic [31:0] rt);
    dec_t d;
    int signed s;
    int signed t;
    logic [31:0] seq;
    logic [31:0] off;
    s   = $signed(rs);
    t   = $signed(rt);
    seq = p + 32'd4;
    off = 32'($signed(ins[15:0])) * 32'd4;
    d   = '0;
    d.lreg = 5'd31;
    d.tgt  = seq + off;
    case (ins[31:26])
      6'd0: begin
        if (ins[5:0] == 6'd8) begin d.xfer = 1; d.taken = 1; d.tgt = rs; end
        if (ins[5:0] == 6'd9) begin d.xfer = 1; d.taken = 1; d.tgt = rs; d.link = 1; d.lreg = ins[15:11]; end
      end
      6'd1: begin
        case (ins[20:16])
          5'd0:  begin d.xfer = 1; d.taken = (s < 0);  end
          5'd1:  begin d.xfer = 1; d.taken = (s >= 0); end
          5'd16: begin d.xfer = 1; d.taken = (s < 0);  d.link = 1; end
          5'd17: begin d.xfer = 1; d.taken = (s >= 0); d.link = 1; end
          default: ;
        endcase
      end
      6'd2: begin d.xfer = 1; d.taken = 1; d.tgt = {seq[31:28], ins[25:0], 2'b00}; end
      6'd3: begin d.xfer = 1; d.taken = 1; d.link = 1; d.tgt = {seq[31:28], ins[25:0], 2'b00}; end
      6'd4: begin d.xfer = 1; d.taken = (s == t); end
      6'd5: begin d.xfer = 1; d.taken = (s != t); end
      6'd6: begin d.xfer = 1; d.taken = (s <= 0); end
      6'd7: begin d.xfer = 1; d.taken = (s > 0);  end
      default: ;
    endcase
    return d;
  endfunction

  // Model state: a pending jump is one cycle long and blocks the next
  // instruction (the delay slot) from starting a transfer or linking.
  logic        m_ready = 1'b0;
  logic        m_pend  = 1'b0;
  logic [31:0] m_adr   = '0;
  logic        m_dslot = 1'b0;

  always @(posedge clk) begin
    automatic dec_t d = model(pc, instr, rs_val, rt_val);
    if (rst) begin
      m_ready = 1'b1;
      m_pend  = 1'b0;
      m_adr   = '0;
      m_dslot = 1'b0;
    end else begin
      m_dslot = m_pend && instr_valid && d.xfer;
      if (!m_pend && instr_valid && d.xfer && d.taken) begin
        m_pend = 1'b1;
        m_adr  = d.tgt;
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    automatic dec_t d = model(pc, instr, rs_val, rt_val);
    automatic logic exp_we = instr_valid && !m_pend && d.link && (d.lreg != 5'd0);
    if (m_ready) begin
      chk("m_jmp", 32'(jmp), 32'(m_pend));
      chk("m_jmp_adr", jmp_adr, m_adr);
      chk("m_dslot_err", 32'(dslot_err), 32'(m_dslot));
      chk("m_link_we", 32'(link_we), 32'(exp_we));
      chk("m_link_val", link_val, pc + 32'd8);
      if (d.link) chk("m_link_reg", 32'(link_reg), 32'(d.lreg));
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [31:0] p,
                     input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    rst = r; instr_valid = v; pc = p; instr = ins; rs_val = rs; rt_val = rt;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_jmp", 32'(jmp), 0);
    chk("rst_adr", jmp_adr, 0);
    chk("rst_dslot", 32'(dslot_err), 0);

    // BEQ taken
    cyc(0, 1, 32'h100, 32'h1022_0004, 5, 5);
    chk("beq_n_jmp", 32'(jmp), 0);
    cyc(0, 1, 32'h104, 0, 0, 0);
    chk("beq_n1_jmp", 32'(jmp), 1);
    chk("beq_n1_adr", jmp_adr, 32'h0000_0114);
    cyc(0, 1, 32'h114, 0, 0, 0);
    chk("beq_n2_jmp", 32'(jmp), 0);

    // BNE not taken
    cyc(0, 1, 32'h100, 32'h1422_0004, 7, 7);
    chk("bne_link_we", 32'(link_we), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'h104 + 32'(i) * 4, 0, 0, 0);
      chk("bne_jmp", 32'(jmp), 0);
    end

    // JAL
    cyc(0, 1, 32'h40, 32'h0C00_0040, 0, 0);
    chk("jal_we", 32'(link_we), 1);
    chk("jal_reg", 32'(link_reg), 31);
    chk("jal_val", link_val, 32'h48);
    cyc(0, 1, 32'h44, 0, 0, 0);
    chk("jal_jmp", 32'(jmp), 1);
    chk("jal_adr", jmp_adr, 32'h100);
    cyc(0, 1, 32'h100, 0, 0, 0);

    // BLTZAL taken, then not taken
    cyc(0, 1, 32'h200, 32'h0430_FFFF, 32'hFFFF_FFFF, 0);
    chk("bltzal_we", 32'(link_we), 1);
    chk("bltzal_reg", 32'(link_reg), 31);
    chk("bltzal_val", link_val, 32'h208);
    cyc(0, 1, 32'h204, 0, 0, 0);
    chk("bltzal_jmp", 32'(jmp), 1);
    chk("bltzal_adr", jmp_adr, 32'h200);
    cyc(0, 1, 32'h200, 32'h0430_FFFF, 0, 0);
    chk("bltzal_nt_we", 32'(link_we), 1);
    chk("bltzal_nt_val", link_val, 32'h208);
    cyc(0, 1, 32'h204, 0, 0, 0);
    chk("bltzal_nt_jmp", 32'(jmp), 0);
    chk("bltzal_nt_adr", jmp_adr, 32'h200);

    // J with taken BEQ in its delay slot
    cyc(0, 1, 32'h300, 32'h0800_0080, 0, 0);
    cyc(0, 1, 32'h304, 32'h1022_0004, 3, 3);
    chk("ds_jmp", 32'(jmp), 1);
    chk("ds_adr", jmp_adr, 32'h200);
    chk("ds_link_we", 32'(link_we), 0);
    cyc(0, 1, 32'h200, 0, 0, 0);
    chk("ds_err", 32'(dslot_err), 1);
    chk("ds_jmp_after", 32'(jmp), 0);
    chk("ds_adr_after", jmp_adr, 32'h200);
    cyc(0, 1, 32'h204, 0, 0, 0);
    chk("ds_err_clr", 32'(dslot_err), 0);

    // JAL in a delay slot must not link
    cyc(0, 1, 32'h300, 32'h0800_0080, 0, 0);
    cyc(0, 1, 32'h304, 32'h0C00_0040, 0, 0);
    chk("ds_jal_we", 32'(link_we), 0);
    cyc(0, 1, 32'h200, 0, 0, 0);
    chk("ds_jal_err", 32'(dslot_err), 1);

    // JALR rd=0
    cyc(0, 1, 32'h400, 32'h0020_0009, 32'h1234_5678, 0);
    chk("jalr_we", 32'(link_we), 0);
    cyc(0, 1, 32'h404, 0, 0, 0);
    chk("jalr_jmp", 32'(jmp), 1);
    chk("jalr_adr", jmp_adr, 32'h1234_5678);
    cyc(0, 1, 32'h1234_5678, 0, 0, 0);

    // Reset during SLOT
    cyc(0, 1, 32'h500, 32'h0800_0080, 0, 0);
    cyc(1, 1, 32'h504, 0, 0, 0);
    chk("rslot_jmp_pre", 32'(jmp), 1);
    cyc(0, 1, 32'h508, 0, 0, 0);
    chk("rslot_jmp", 32'(jmp), 0);
    chk("rslot_adr", jmp_adr, 0);

    // Invalid instructions have no effect; invalid slot transfer raises no error
    cyc(0, 0, 32'h600, 32'h0C00_0040, 0, 0);
    chk("inv_we", 32'(link_we), 0);
    cyc(0, 1, 32'h604, 0, 0, 0);
    chk("inv_jmp", 32'(jmp), 0);
    cyc(0, 1, 32'h700, 32'h0800_0080, 0, 0);
    cyc(0, 0, 32'h704, 32'h1022_0004, 1, 1);
    cyc(0, 1, 32'h200, 0, 0, 0);
    chk("inv_ds_err", 32'(dslot_err), 0);

    // BGTZ / BLEZ boundary at zero
    cyc(0, 1, 32'h800, 32'h1C20_0002, 0, 0);
    cyc(0, 1, 32'h804, 0, 0, 0);
    chk("bgtz0_jmp", 32'(jmp), 0);
    cyc(0, 1, 32'h800, 32'h1820_FFFE, 0, 0);
    cyc(0, 1, 32'h804, 0, 0, 0);
    chk("blez0_jmp", 32'(jmp), 1);
    chk("blez0_adr", jmp_adr, 32'h7FC);
    cyc(0, 1, 32'h7FC, 0, 0, 0);
    cyc(0, 1, 32'h800, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Control-transfer resolver for the single-cycle MIPS core; drives the `jmp`/`jmp_adr` inputs of the program counter. It decodes the instruction at the current `pc`, evaluates branch conditions on register operands, and computes targets. Each taken transfer is registered so that it takes effect after the architectural branch delay slot. It also supplies link-register write data for JAL/JALR/BLTZAL/BGEZAL.

## Interface
Parameters:
- none (all widths fixed at 32-bit MIPS)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc  in  32  address of the instruction currently executing
- instr  in  32  instruction word at `pc`
- instr_valid  in  1  `instr` is architecturally executing this cycle
- rs_val  in  32  register-file read of instr[25:21]
- rt_val  in  32  register-file read of instr[20:16]
- jmp  out  1  registered; PC loads `jmp_adr` at the next edge
- jmp_adr  out  32  registered pending target
- link_we  out  1  combinational; write `link_val` to `link_reg` this cycle
- link_reg  out  5  combinational link destination
- link_val  out  32  combinational, pc + 8
- dslot_err  out  1  registered one-cycle pulse; control transfer found in delay slot

## Operation
- Decoded transfers (opcode instr[31:26]):
  - SPECIAL 000000 with funct JR 001000 or JALR 001001
  - REGIMM 000001 with rt field BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001
  - J 000010, JAL 000011, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111
- Conditions (rs_val, rt_val signed): BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ/BLTZAL rs<0; BGEZ/BGEZAL rs>=0. J/JAL/JR/JALR are always taken.
- Targets, all mod 2^32:
  - Branches: pc + 4 + (sign_ext(instr[15:0]) << 2).
  - J/JAL: {(pc+4)[31:28], instr[25:0], 2'b00}.
  - JR/JALR: rs_val used unmodified; no alignment check.
- Link:
  - JAL: link_reg=31.
  - JALR: link_reg=instr[15:11].
  - BLTZAL/BGEZAL: link_reg=31. Link is written whether or not the branch is taken.
  - link_val=pc+8 in all cases.
  - link_we is suppressed when link_reg==0.
- FSM with states IDLE and SLOT:
  - IDLE, instr_valid, taken transfer decoded: capture target into jmp_adr, go to SLOT.
  - IDLE otherwise: stay; jmp_adr holds its last value.
  - SLOT: the delay-slot instruction executes normally, except that any control transfer decoded in it is ignored. It captures no target and drives link_we=0. If that transfer was valid, dslot_err pulses next cycle. Next state is IDLE unconditionally.
- jmp = (state==SLOT).
- instr_valid=0: no decode effects (no capture, link_we=0, no dslot_err); the SLOT→IDLE transition still happens.

## Timing
- Reset values: jmp=0, jmp_adr=32'h0, dslot_err=0, state=IDLE. Combinational link outputs follow their inputs.
- Latency:
  - Branch at pc=P in cycle N: jmp=1 during cycle N+1, while the delay slot P+4 executes.
  - PC holds the target in cycle N+2.
  - jmp is high for exactly one cycle per taken transfer.
- Back-to-back: the earliest cycle a new transfer can be captured is N+2.
- rst asserted in any cycle, including SLOT: the pending jump is discarded and outputs show reset values next cycle. rst has priority over capture.
- Not-taken branch: jmp stays 0; the delay slot and following instructions run sequentially.

## Structure
- Shared package `mips_pkg`: opcode, funct, and REGIMM rt localparams; REG_RA=5'd31; instruction field index constants. The package is reused by decode and the ALU.
- Sub-module `branch_cmp`: pure combinational evaluation of rs_val/rt_val to the taken flag, given a condition select. The FSM, target adders, and link logic stay in the top level.

## Test plan
- BEQ at pc=0x100, rs=rt=5, imm=0x0004 → cycle N+1 jmp=1, jmp_adr=0x0000_0114; cycle N+2 jmp=0.
- BNE at pc=0x100, rs=rt=7 → jmp stays 0 for 4 cycles; link_we=0.
- JAL at pc=0x0000_0040, index=0x0000040 → same cycle link_we=1, link_reg=31, link_val=0x0000_0048; next cycle jmp=1, jmp_adr=0x0000_0100.
- BLTZAL at pc=0x200, rs=0xFFFF_FFFF, imm=0xFFFF → link_val=0x208 to r31; next cycle jmp_adr=0x0000_0200. Repeat with rs=0 → link still written, jmp=0.
- J then taken BEQ in the delay slot → only the J target appears; no link from BEQ; dslot_err=1 for one cycle; jmp=0 the cycle after.
- JALR rd=0, rs=0x1234_5678 → link_we=0, jmp_adr=0x1234_5678. Separately, assert rst during a SLOT cycle → next cycle jmp=0, jmp_adr=0.
